muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 21 ++
 rtl/alu.sv | 23 ++
 rtl/muldiv_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller and its ALU.
// Holds the operation codes, the FSM state codes and the ALU opcodes.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUBU = 6'b100011;

endpackage

// File: rtl/alu.sv
// Width-parameterised add/subtract unit shared by the multiply and divide steps.
module alu
    import muldiv_ctrl_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [5:0]       aluop,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] result
);

    // Opcode decode: only the unsigned add and subtract are meaningful here.
    always_comb begin
        result = {Width{1'b0}};
        case (aluop)
            ALU_ADDU: result = a + b;
            ALU_SUBU: result = a - b;
            default:  result = {Width{1'b0}};
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative unsigned multiply/divide controller with architectural HI/LO registers.
// One bit per cycle: shift-add for MULTU, restoring shift-subtract for DIVU.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Width-1:0] in1,
    input  logic [Width-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] hi,
    output logic [Width-1:0] lo
);

    localparam int CntW = $clog2(Width) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Width);

    state_e           state_r, state_s;
    mdop_e            op_r, op_s;
    logic [CntW-1:0]  cnt_r, cnt_s;
    logic [Width-1:0] operand_r, operand_s;
    logic [Width-1:0] hi_r, hi_s;
    logic [Width-1:0] lo_r, lo_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [5:0]       aluop_s;
    logic [Width-1:0] alu_a_s, alu_b_s, alu_y_s;
    logic [Width-1:0] rs_s;
    logic             ge_s;
    logic             carry_s;

    // operand_r is the multiplicand for MULTU and the divisor for DIVU.
    assign rs_s    = {hi_r[Width-2:0], lo_r[Width-1]};
    assign ge_s    = hi_r[Width-1] | ~(rs_s < operand_r);
    assign carry_s = (alu_y_s < hi_r);

    alu #(.Width(Width)) u_alu (
        .aluop  (aluop_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .result (alu_y_s)
    );

    // ALU operand steering for the current iteration.
    always_comb begin
        aluop_s = ALU_ADDU;
        alu_a_s = hi_r;
        alu_b_s = {Width{1'b0}};
        if (op_r == OP_DIVU) begin
            aluop_s = ALU_SUBU;
            alu_a_s = rs_s;
            alu_b_s = operand_r;
        end else begin
            aluop_s = ALU_ADDU;
            alu_a_s = hi_r;
            alu_b_s = lo_r[0] ? operand_r : {Width{1'b0}};
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s   = state_r;
        op_s      = op_r;
        cnt_s     = cnt_r;
        operand_s = operand_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            op_s      = OP_MULTU;
                            operand_s = in1;
                            hi_s      = {Width{1'b0}};
                            lo_s      = in2;
                            cnt_s     = {CntW{1'b0}};
                            state_s   = ST_RUN;
                        end
                        OP_DIVU: begin
                            op_s      = OP_DIVU;
                            operand_s = in2;
                            hi_s      = {Width{1'b0}};
                            lo_s      = in1;
                            cnt_s     = {CntW{1'b0}};
                            state_s   = ST_RUN;
                        end
                        OP_MTHI: hi_s = in1;
                        OP_MTLO: lo_s = in1;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // After the last iteration one extra RUN cycle hands off to DONE.
                if (cnt_r == CntLast) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                    if (op_r == OP_DIVU) begin
                        hi_s = ge_s ? alu_y_s : rs_s;
                        lo_s = {lo_r[Width-2:0], ge_s};
                    end else begin
                        hi_s = {carry_s, alu_y_s[Width-1:1]};
                        lo_s = {alu_y_s[0], lo_r[Width-1:1]};
                    end
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_MULTU;
            cnt_r     <= {CntW{1'b0}};
            operand_r <= {Width{1'b0}};
            hi_r      <= {Width{1'b0}};
            lo_r      <= {Width{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            op_r      <= op_s;
            cnt_r     <= cnt_s;
            operand_r <= operand_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
